// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD write engine.
package lcd_pkg;

   typedef enum logic [2:0] {
      POWERUP,
      SETUP,
      PULSE,
      WAIT,
      IDLE
   } lcd_state_t;

   // What the command currently on the bus is, so WAIT knows where to go next.
   typedef enum logic [1:0] {
      OP_INIT,
      OP_CHAR,
      OP_ADDR
   } lcd_op_t;

   localparam logic [7:0] LCD_FUNC_8BIT = 8'h38;
   localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
   localparam logic [7:0] LCD_CLEAR     = 8'h01;
   localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
   localparam logic [7:0] LCD_LINE1     = 8'h80;
   localparam logic [7:0] LCD_LINE2     = 8'hC0;

   localparam int LCD_INIT_LEN = 7;
   localparam int LCD_COLS     = 16;

   // HD44780 8-bit power-on command list, indexed 0..LCD_INIT_LEN-1.
   function automatic logic [7:0] lcd_init_cmd(input logic [2:0] idx);
      logic [7:0] cmd;
      case (idx)
         3'd0, 3'd1, 3'd2: cmd = LCD_FUNC_8BIT;
         3'd3:             cmd = LCD_DISP_ON;
         3'd4:             cmd = LCD_CLEAR;
         3'd5:             cmd = LCD_ENTRY_INC;
         default:          cmd = LCD_LINE1;
      endcase
      return cmd;
   endfunction

   function automatic int lcd_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by every timed phase of the LCD writer.
// Loading N makes done_o pulse in the N-th cycle after the load edge, so a
// phase that reloads on done lasts exactly N cycles. The timer comes out of
// reset already loaded with RESET_COUNT so the power-on wait needs no kick.
module lcd_delay_timer #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_COUNT = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] count_i,
   output logic             done_o
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             active_q, active_d;

   // Next count: a load wins, otherwise step down until the final cycle.
   always_comb begin
      count_d  = count_q;
      active_d = active_q;
      if (load_i) begin
         count_d  = count_i;
         active_d = (count_i != '0);
      end else if (active_q) begin
         count_d  = count_q - ONE;
         active_d = (count_q != ONE);
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q  <= RESET_COUNT;
         active_q <= (RESET_COUNT != '0);
      end else begin
         count_q  <= count_d;
         active_q <= active_d;
      end
   end

   assign done_o = active_q && (count_q == ONE);

endmodule

// File: rtl/lcd_writer.sv
// Character-LCD write engine: runs the HD44780 power-on sequence, then takes
// one character per data_ready/lcd_busy handshake and strobes it onto the
// panel, inserting line-address commands when the cursor crosses a line.
// Every count parameter must be at least 1.
module lcd_writer
   import lcd_pkg::*;
#(
   parameter int POWERUP_CYCLES    = 750000,
   parameter int SETUP_CYCLES      = 3,
   parameter int E_HIGH_CYCLES     = 25,
   parameter int CMD_WAIT_CYCLES   = 2500,
   parameter int CLEAR_WAIT_CYCLES = 82000
) (
   input  logic       clock,
   input  logic       internal_reset_n,
   input  logic       data_ready,
   input  logic [7:0] data_in,
   output logic       lcd_busy,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data
);

   localparam int MAX_CNT = lcd_max(lcd_max(POWERUP_CYCLES, SETUP_CYCLES),
                                    lcd_max(lcd_max(E_HIGH_CYCLES, CMD_WAIT_CYCLES),
                                            CLEAR_WAIT_CYCLES));
   localparam int TW = $clog2(MAX_CNT) + 1;

   localparam logic [TW-1:0] CNT_POWERUP = TW'(POWERUP_CYCLES);
   localparam logic [TW-1:0] CNT_SETUP   = TW'(SETUP_CYCLES);
   // A character spends one extra setup cycle: the accept edge itself.
   localparam logic [TW-1:0] CNT_ACCEPT  = TW'(SETUP_CYCLES + 1);
   localparam logic [TW-1:0] CNT_E_HIGH  = TW'(E_HIGH_CYCLES);
   localparam logic [TW-1:0] CNT_CMD     = TW'(CMD_WAIT_CYCLES);
   localparam logic [TW-1:0] CNT_CLEAR   = TW'(CLEAR_WAIT_CYCLES);

   localparam logic [2:0] LAST_INIT = 3'(LCD_INIT_LEN - 1);
   localparam logic [4:0] LINE2_COL = 5'(LCD_COLS);

   lcd_state_t       state_q, state_d;
   lcd_op_t          op_q, op_d;
   logic             busy_q, busy_d;
   logic             e_q, e_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic [4:0]       col_q, col_d;
   logic [2:0]       idx_q, idx_d;
   logic [4:0]       col_next;

   logic             tmr_load;
   logic [TW-1:0]    tmr_count;
   logic             tmr_done;

   lcd_delay_timer #(
      .WIDTH       (TW),
      .RESET_COUNT (CNT_POWERUP)
   ) u_timer (
      .clk_i   (clock),
      .rst_ni  (internal_reset_n),
      .load_i  (tmr_load),
      .count_i (tmr_count),
      .done_o  (tmr_done)
   );

   assign col_next = col_q + 5'd1;

   // Sequencer: advance phases on timer expiry, choose the next command.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      busy_d    = busy_q;
      e_d       = e_q;
      rs_d      = rs_q;
      data_d    = data_q;
      col_d     = col_q;
      idx_d     = idx_q;
      tmr_load  = 1'b0;
      tmr_count = '0;

      unique case (state_q)
         POWERUP: begin
            if (tmr_done) begin
               state_d   = SETUP;
               op_d      = OP_INIT;
               idx_d     = 3'd0;
               rs_d      = 1'b0;
               data_d    = lcd_init_cmd(3'd0);
               tmr_load  = 1'b1;
               tmr_count = CNT_SETUP;
            end
         end

         SETUP: begin
            if (tmr_done) begin
               state_d   = PULSE;
               e_d       = 1'b1;
               tmr_load  = 1'b1;
               tmr_count = CNT_E_HIGH;
            end
         end

         PULSE: begin
            if (tmr_done) begin
               state_d   = WAIT;
               e_d       = 1'b0;
               tmr_load  = 1'b1;
               tmr_count = (op_q == OP_INIT && lcd_init_cmd(idx_q) == LCD_CLEAR)
                           ? CNT_CLEAR : CNT_CMD;
            end
         end

         WAIT: begin
            if (tmr_done) begin
               unique case (op_q)
                  OP_INIT: begin
                     if (idx_q == LAST_INIT) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                     end else begin
                        state_d   = SETUP;
                        idx_d     = idx_q + 3'd1;
                        data_d    = lcd_init_cmd(idx_q + 3'd1);
                        tmr_load  = 1'b1;
                        tmr_count = CNT_SETUP;
                     end
                  end
                  OP_CHAR: begin
                     col_d = col_next;
                     if (col_next == LINE2_COL || col_next == 5'd0) begin
                        state_d   = SETUP;
                        op_d      = OP_ADDR;
                        rs_d      = 1'b0;
                        data_d    = (col_next == LINE2_COL) ? LCD_LINE2 : LCD_LINE1;
                        tmr_load  = 1'b1;
                        tmr_count = CNT_SETUP;
                     end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                     end
                  end
                  default: begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                  end
               endcase
            end
         end

         IDLE: begin
            if (data_ready) begin
               state_d   = SETUP;
               op_d      = OP_CHAR;
               busy_d    = 1'b1;
               rs_d      = 1'b1;
               data_d    = data_in;
               tmr_load  = 1'b1;
               tmr_count = CNT_ACCEPT;
            end
         end

         default: begin
            state_d = POWERUP;
         end
      endcase
   end

   // State and registered panel outputs; reset forces lcd_e low immediately.
   always_ff @(posedge clock or negedge internal_reset_n) begin
      if (!internal_reset_n) begin
         state_q <= POWERUP;
         op_q    <= OP_INIT;
         busy_q  <= 1'b1;
         e_q     <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         col_q   <= 5'd0;
         idx_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         busy_q  <= busy_d;
         e_q     <= e_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         col_q   <= col_d;
         idx_q   <= idx_d;
      end
   end

   assign lcd_busy = busy_q;
   assign lcd_e    = e_q;
   assign lcd_rs   = rs_q;
   assign lcd_rw   = 1'b0;
   assign lcd_data = data_q;

endmodule
